// File: rtl/cpu_clk_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_clk_ctrl_if
// Signal bundle between the CPU clock controller and its environment.
//   clkdiv   : free-running divider count (into controller)
//   tap_sel  : clkdiv bit that paces RUN mode (into controller)
//   mode     : 0 = run, 1 = single-step (into controller)
//   step_btn : raw asynchronous step push-button, active-high (into controller)
//   halt_req : level request to stop the CPU (into controller)
//   cpu_en   : one-cycle CPU clock-enable pulse (from controller)
//   state    : FSM state 00 HALT, 01 RUN, 10 STEP (from controller)
//   en_cnt   : count of cpu_en pulses issued (from controller)
// slave  = the controller, master = whatever drives it.
// ---------------------------------------------------------------------------
interface cpu_clk_ctrl_if;
    logic [31:0] clkdiv;
    logic [4:0]  tap_sel;
    logic        mode;
    logic        step_btn;
    logic        halt_req;
    logic        cpu_en;
    logic [1:0]  state;
    logic [15:0] en_cnt;

    modport slave (
        input  clkdiv, tap_sel, mode, step_btn, halt_req,
        output cpu_en, state, en_cnt
    );

    modport master (
        output clkdiv, tap_sel, mode, step_btn, halt_req,
        input  cpu_en, state, en_cnt
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clk_ctrl
// Generates a one-cycle CPU clock-enable pulse. In RUN the pulse follows each
// rising edge of a selectable clkdiv bit; in STEP it follows each debounced
// press of the step button; HALT (or halt_req) blocks all pulses.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : cpu_clk_ctrl_if.slave (clkdiv, tap_sel, mode, step_btn, halt_req
//         in; cpu_en, state, en_cnt out)
// Parameter DEB_CYCLES: stable cycles before the debounced button changes
// level (2..65535).
// ---------------------------------------------------------------------------
module cpu_clk_ctrl #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic           clk,
    input  logic           rst,
    cpu_clk_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    state_t      state_reg;
    logic        cpu_en_reg;
    logic [15:0] en_cnt_reg;

    logic        tap_q_reg;
    logic [4:0]  tap_sel_q_reg;

    logic        sync1_reg;
    logic        btn_s_reg;
    logic        db_reg;
    logic        db_q_reg;
    logic [15:0] deb_cnt_reg;

    logic        tap_bit;
    logic        run_edge;
    logic        step_edge;

    // Pace tap: a change of tap_sel masks edge detection for that one cycle,
    // because tap_q still holds the previously selected bit.
    assign tap_bit  = bus.clkdiv[bus.tap_sel];
    assign run_edge = tap_bit & ~tap_q_reg & (bus.tap_sel == tap_sel_q_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_q_reg     <= 1'b0;
            tap_sel_q_reg <= 5'd0;
        end else begin
            tap_q_reg     <= tap_bit;
            tap_sel_q_reg <= bus.tap_sel;
        end
    end

    // Two-flop synchroniser for the raw push-button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            btn_s_reg <= 1'b0;
        end else begin
            sync1_reg <= bus.step_btn;
            btn_s_reg <= sync1_reg;
        end
    end

    // Debouncer: db follows btn_s only after it has differed for DEB_CYCLES
    // consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_reg      <= 1'b0;
            db_q_reg    <= 1'b0;
            deb_cnt_reg <= 16'd0;
        end else begin
            db_q_reg <= db_reg;
            if (btn_s_reg == db_reg) begin
                deb_cnt_reg <= 16'd0;
            end else if (deb_cnt_reg == DEB_CYCLES - 16'd1) begin
                db_reg      <= btn_s_reg;
                deb_cnt_reg <= 16'd0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 16'd1;
            end
        end
    end

    assign step_edge = db_reg & ~db_q_reg;

    // Control FSM with registered pulse output. Eligibility uses the current
    // (pre-transition) state; edges not consumed here are simply dropped.
    // The ~cpu_en_reg term guarantees a gap cycle between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_HALT;
            cpu_en_reg <= 1'b0;
        end else if (bus.halt_req) begin
            state_reg  <= ST_HALT;
            cpu_en_reg <= 1'b0;
        end else begin
            state_reg <= bus.mode ? ST_STEP : ST_RUN;
            case (state_reg)
                ST_RUN:  cpu_en_reg <= run_edge & ~cpu_en_reg;
                ST_STEP: cpu_en_reg <= step_edge & ~cpu_en_reg;
                default: cpu_en_reg <= 1'b0;
            endcase
        end
    end

    // Pulse counter: bumps at the end of each cycle in which cpu_en was high;
    // wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_cnt_reg <= 16'd0;
        end else if (cpu_en_reg) begin
            en_cnt_reg <= en_cnt_reg + 16'd1;
        end
    end

    assign bus.cpu_en = cpu_en_reg;
    assign bus.state  = state_reg;
    assign bus.en_cnt = en_cnt_reg;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_clk_ctrl
// Directed bench for cpu_clk_ctrl with DEB_CYCLES = 4 and a 20 ns clock.
// clkdiv is a free-running count advancing on every rising clock edge.
// ---------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] div_cnt = 32'd0;
    int          n_checks = 0;
    int          n_pass   = 0;

    cpu_clk_ctrl_if bus ();

    cpu_clk_ctrl #(
        .DEB_CYCLES (16'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) div_cnt <= div_cnt + 32'd1;
    assign bus.clkdiv = div_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-18s got %0h", tag, got);
        end else begin
            $display("FAIL %-18s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; leave time 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until cpu_en is seen high; returns ticks taken (max on timeout).
    task automatic wait_pulse(input string tag, input int max, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < max) begin
            tick();
            n++;
            if (bus.cpu_en === 1'b1) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            $display("FAIL %-18s got no pulse expected pulse within %0d cycles", tag, max);
        end
    endtask

    // Tick n times and count the cycles with cpu_en high.
    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.cpu_en === 1'b1) pulses++;
        end
    endtask

    initial begin
        int d;
        int p;
        int p2;
        int n;

        rst          = 1'b0;
        bus.tap_sel  = 5'd2;
        bus.mode     = 1'b0;
        bus.step_btn = 1'b0;
        bus.halt_req = 1'b0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_state", {30'd0, bus.state}, 32'd0);
        check_eq("rst_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        check_eq("rst_en_cnt", {16'd0, bus.en_cnt}, 32'd0);

        // Run pacing on clkdiv[2]: pulse one cycle after the bit rises
        rst = 1'b1;
        tick();
        check_eq("run_enter", {30'd0, bus.state}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_pulse("run_pulse", 20, d);
            if (i > 0) check_eq("run_interval", d, 32'd7);
            check_eq("run_phase", {29'd0, div_cnt[2:0]}, 32'd5);
            tick();
            check_eq("run_width", {31'd0, bus.cpu_en}, 32'd0);
        end
        check_eq("run_en_cnt", {16'd0, bus.en_cnt}, 32'd4);

        // Single step: press seen after 2 sync + 4 debounce + 1 cycles
        bus.mode = 1'b1;
        tick();
        check_eq("step_enter", {30'd0, bus.state}, 32'd2);
        bus.step_btn = 1'b1;
        wait_pulse("step_pulse", 20, d);
        check_eq("step_latency", d, 32'd7);
        run_count(3, p);
        bus.step_btn = 1'b0;
        run_count(12, p2);
        check_eq("step_single", p + p2, 32'd0);

        // Two-cycle glitch must not produce a pulse
        bus.step_btn = 1'b1;
        tick();
        tick();
        bus.step_btn = 1'b0;
        run_count(15, p);
        check_eq("step_glitch", p, 32'd0);

        // Halt has priority over a run edge in the same cycle
        bus.mode = 1'b0;
        tick();
        check_eq("run_reenter", {30'd0, bus.state}, 32'd1);
        n = 0;
        while (div_cnt[2:0] != 3'd4 && n < 16) begin
            tick();
            n++;
        end
        bus.halt_req = 1'b1;
        tick();
        check_eq("halt_no_pulse", {31'd0, bus.cpu_en}, 32'd0);
        check_eq("halt_state", {30'd0, bus.state}, 32'd0);
        bus.halt_req = 1'b0;
        tick();
        check_eq("halt_release", {30'd0, bus.state}, 32'd1);
        wait_pulse("halt_resume", 20, d);
        check_eq("halt_resume_dly", d, 32'd7);
        check_eq("halt_resume_ph", {29'd0, div_cnt[2:0]}, 32'd5);

        // Tap change 2->5 with clkdiv[5]=1 and old tap_q=0
        tick();
        n = 0;
        while (div_cnt[5:0] != 6'd33 && n < 80) begin
            tick();
            n++;
        end
        bus.tap_sel = 5'd5;
        tick();
        check_eq("tap_spurious", {31'd0, bus.cpu_en}, 32'd0);
        wait_pulse("tap_pulse", 100, d);
        check_eq("tap_next_dly", d, 32'd63);
        check_eq("tap_next_ph", {26'd0, div_cnt[5:0]}, 32'd33);

        // Step press during RUN is dropped and not replayed in STEP
        tick();
        bus.step_btn = 1'b1;
        run_count(10, p);
        bus.step_btn = 1'b0;
        check_eq("run_step_drop", p, 32'd0);
        bus.mode = 1'b1;
        run_count(12, p);
        check_eq("step_no_pending", p, 32'd0);
        check_eq("step_state", {30'd0, bus.state}, 32'd2);

        // Counter wrap: preload FFFE, two pulses take it through FFFF to 0
        bus.mode    = 1'b0;
        bus.tap_sel = 5'd2;
        wait_pulse("wrap_sync", 20, d);
        tick();
        force dut.en_cnt_reg = 16'hFFFE;
        #1;
        release dut.en_cnt_reg;
        wait_pulse("wrap_p1", 20, d);
        tick();
        check_eq("wrap_ffff", {16'd0, bus.en_cnt}, 32'h0000_FFFF);
        wait_pulse("wrap_p2", 20, d);
        tick();
        check_eq("wrap_zero", {16'd0, bus.en_cnt}, 32'd0);
        wait_pulse("wrap_p3", 20, d);
        tick();
        check_eq("wrap_one", {16'd0, bus.en_cnt}, 32'd1);

        // Asynchronous reset in the middle of a pulse
        wait_pulse("pre_rst", 20, d);
        check_eq("pre_rst_dly", d, 32'd7);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        check_eq("arst_state", {30'd0, bus.state}, 32'd0);
        check_eq("arst_en_cnt", {16'd0, bus.en_cnt}, 32'd0);
        bus.halt_req = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check_eq("post_rst_halt", {30'd0, bus.state}, 32'd0);
        bus.halt_req = 1'b0;
        tick();
        check_eq("post_rst_run", {30'd0, bus.state}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
